reflet_fetch_wb: RTL and testbench
==================================

Name: reflet_fetch_wb

Overview:
- Sequencer that feeds and drains the ALU stage.
- Fetches one instruction byte from memory through a req/ack handshake at the address held in PC.
- Presents the instruction and the register operands to the ALU, then writes the ALU result into the 16-entry register bank at the index the ALU selects.
- Advances PC, or loads PC when the ALU targets it. Owns the architectural register file, including the working register, the status register (SR) and PC.

Parameters:
- wordsize, 16, width of every register and of the memory address.
- sr_index, 12, register-bank index of SR.
- pc_index, 14, register-bank index of PC.
- slp_opcode, 8'h08, full instruction byte that enters SLEEP after writeback.

Ports:
- clk  input  1  core clock; every register updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_addr  output  wordsize  fetch address; equals PC.
- mem_req  output  1  fetch request.
- mem_ack  input  1  memory ack; mem_data_in is valid in the same cycle.
- mem_data_in  input  8  instruction byte from memory.
- instruction  output  8  latched instruction to the ALU.
- working_register  output  wordsize  register 0.
- other_register  output  wordsize  register at index instruction[3:0].
- status_register  output  wordsize  register at index sr_index.
- alu_out  input  wordsize  ALU result.
- alu_out_reg  input  4  destination register index from the ALU.
- wake  input  1  leaves SLEEP.
- sleeping  output  1  high while in SLEEP.

Behaviour:
- Reset (reset low, asynchronous):
  - All 16 registers clear to 0, so PC=0.
  - instruction=8'h00, mem_req=0, sleeping=0, state=FETCH.
  - Deassertion takes effect at the next clk edge.
- FSM states: FETCH, EXEC, SLEEP.
- FETCH:
  - mem_req=1 and mem_addr=PC, held stable until ack.
  - Cycle with mem_ack=1: instruction<=mem_data_in, mem_req<=0, next state EXEC.
  - mem_ack=0: remain in FETCH with no register change. No timeout.
- EXEC (exactly one cycle):
  - instruction is stable; outputs are combinational from the bank and the ALU responds combinationally.
  - At the clock edge, bank[alu_out_reg]<=alu_out.
  - If alu_out_reg != pc_index: PC<=PC+1, modulo 2^wordsize, so 16'hFFFF wraps to 0.
  - If alu_out_reg == pc_index: PC<=alu_out and there is no increment (jump taken).
  - alu_out_reg==0 with a no-op ALU result is a plain write of the returned value to R0. There is no separate write enable.
  - Next state: SLEEP if instruction==slp_opcode, else FETCH.
- SLEEP:
  - sleeping=1, mem_req=0, no register writes.
  - wake=1 at a clock edge: next state FETCH, sleeping<=0.
  - A wake high during EXEC of slp is ignored; SLEEP still lasts at least one cycle.
- Fetch rate: minimum 2 cycles per instruction (FETCH with immediate ack, then EXEC).
- Read ports:
  - other_register index instruction[3:0]==sr_index or pc_index returns the current (pre-write) value.
  - During EXEC, PC reads as the address of the current instruction.
- Reset mid-operation: an in-flight request is abandoned and mem_req drops asynchronously. A late mem_ack after reset, while in FETCH, is accepted as the response to PC=0.
- mem_ack is ignored in EXEC and SLEEP.
- Target size: roughly 150-250 lines of RTL.

Test Plan:
- Reset then mem_ack tied high:
  - mem_addr sequence 0,1,2 on successive FETCH cycles.
  - mem_req high exactly one cycle per instruction.
  - PC=3 after three EXECs.
- Writeback:
  - Feed instruction 8'h35; ALU model returns alu_out=16'h1234, alu_out_reg=5.
  - Next cycle: R5=16'h1234 and other_register (index 5) reads 16'h1234.
  - PC incremented by 1.
- Jump:
  - Preload via writeback R0=16'h0040; ALU returns alu_out_reg=pc_index, alu_out=16'h0040.
  - Next FETCH mem_addr=16'h0040, not 16'h0041.
- Wrap:
  - Jump to 16'hFFFF, execute one non-jump instruction: next mem_addr=16'h0000.
- Ack latency:
  - Hold mem_ack low 5 cycles with mem_data_in toggling: mem_req and mem_addr stable, instruction unchanged.
  - Ack on cycle 6: the value on mem_data_in at that cycle is latched.
- Sleep:
  - Fetch 8'h08: sleeping rises after EXEC and mem_req stays 0 for 10 cycles.
  - Pulse wake: FETCH resumes at PC+1.
  - Assert reset during SLEEP: sleeping=0 and PC=0 immediately.

Source files
------------

// File: rtl/reflet_fetch_wb.sv
// Fetch/writeback sequencer for the Reflet core: fetches one instruction byte,
// hands it to the ALU, and writes the ALU result back into the 16-entry bank.
module reflet_fetch_wb #(
    parameter int          wordsize   = 16,
    parameter int          sr_index   = 12,
    parameter int          pc_index   = 14,
    parameter logic [7:0]  slp_opcode = 8'h08
) (
    input  logic                clk,
    input  logic                reset,
    output logic [wordsize-1:0] mem_addr,
    output logic                mem_req,
    input  logic                mem_ack,
    input  logic [7:0]          mem_data_in,
    output logic [7:0]          instruction,
    output logic [wordsize-1:0] working_register,
    output logic [wordsize-1:0] other_register,
    output logic [wordsize-1:0] status_register,
    input  logic [wordsize-1:0] alu_out,
    input  logic [3:0]          alu_out_reg,
    input  logic                wake,
    output logic                sleeping
);

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        SLEEP
    } state_t;

    localparam logic [3:0]          SR_SEL  = 4'(sr_index);
    localparam logic [3:0]          PC_SEL  = 4'(pc_index);
    localparam logic [wordsize-1:0] PC_STEP = {{(wordsize-1){1'b0}}, 1'b1};

    state_t              state;
    state_t              next_state;
    logic [wordsize-1:0] bank [16];
    logic [wordsize-1:0] pc;

    assign pc               = bank[PC_SEL];
    assign mem_addr         = pc;
    assign working_register = bank[0];
    assign other_register   = bank[instruction[3:0]];
    assign status_register  = bank[SR_SEL];
    assign sleeping         = (state == SLEEP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH: begin
                if (mem_ack) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (instruction == slp_opcode) begin
                    next_state = SLEEP;
                end else begin
                    next_state = FETCH;
                end
            end
            SLEEP: begin
                if (wake) begin
                    next_state = FETCH;
                end
            end
            default: next_state = FETCH;
        endcase
    end

    // The request is registered so it is held glitch-free for as long as the
    // next state remains FETCH; an ack in FETCH is honoured even before it rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req <= 1'b0;
        end else begin
            mem_req <= (next_state == FETCH);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction <= 8'h00;
        end else if (state == FETCH && mem_ack) begin
            instruction <= mem_data_in;
        end
    end

    // A write that targets PC is the jump; otherwise PC steps past this byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                bank[i] <= '0;
            end
        end else if (state == EXEC) begin
            bank[alu_out_reg] <= alu_out;
            if (alu_out_reg != PC_SEL) begin
                bank[PC_SEL] <= pc + PC_STEP;
            end
        end
    end

endmodule

// File: tb/tb_reflet_fetch_wb.sv
// Scoreboard bench for reflet_fetch_wb: directed instruction stream, fetch
// addresses are queued by the stimulus and matched by a monitor on each handshake.
module tb_reflet_fetch_wb;

    logic        clk;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [7:0]  mem_data_in;
    logic [7:0]  instruction;
    logic [15:0] working_register;
    logic [15:0] other_register;
    logic [15:0] status_register;
    logic [15:0] alu_out;
    logic [3:0]  alu_out_reg;
    logic        wake;
    logic        sleeping;

    int          checks;
    int          errors;
    int          req_cycles;
    logic [15:0] addr_q [$];

    reflet_fetch_wb dut (
        .clk              (clk),
        .reset            (reset),
        .mem_addr         (mem_addr),
        .mem_req          (mem_req),
        .mem_ack          (mem_ack),
        .mem_data_in      (mem_data_in),
        .instruction      (instruction),
        .working_register (working_register),
        .other_register   (other_register),
        .status_register  (status_register),
        .alu_out          (alu_out),
        .alu_out_reg      (alu_out_reg),
        .wake             (wake),
        .sleeping         (sleeping)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] actual,
                                input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every accepted fetch must be at the address the stimulus queued.
    always @(negedge clk) begin
        if (reset && mem_req) begin
            req_cycles++;
        end
        if (reset && mem_req && mem_ack) begin
            if (addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL fetch_unexpected: got %h, expected none", mem_addr);
            end else begin
                check_output("fetch_addr", mem_addr, addr_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        if (!mem_req) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_req: got timeout, expected mem_req");
        end
    endtask

    // One instruction: fetch with immediate ack, then EXEC with the given ALU answer.
    task automatic apply_stimulus(input logic [7:0] opcode, input logic [15:0] aout,
                                  input logic [3:0] areg, input logic [15:0] exp_addr);
        wait_req();
        mem_data_in = opcode;
        mem_ack     = 1'b1;
        addr_q.push_back(exp_addr);
        tick();
        mem_ack     = 1'b0;
        alu_out     = aout;
        alu_out_reg = areg;
        check_output("exec_instr", {8'h00, instruction}, {8'h00, opcode});
        check_output("exec_pc", mem_addr, exp_addr);
        tick();
        alu_out     = 16'h0000;
        alu_out_reg = 4'd1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        req_cycles  = 0;
        reset       = 1'b0;
        mem_ack     = 1'b0;
        mem_data_in = 8'h00;
        alu_out     = 16'h0000;
        alu_out_reg = 4'd1;
        wake        = 1'b0;

        #2;
        check_output("rst_req", {15'd0, mem_req}, 16'h0000);
        check_output("rst_sleep", {15'd0, sleeping}, 16'h0000);
        check_output("rst_instr", {8'h00, instruction}, 16'h0000);
        check_output("rst_pc", mem_addr, 16'h0000);
        check_output("rst_r0", working_register, 16'h0000);
        check_output("rst_sr", status_register, 16'h0000);

        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();

        // Three plain instructions back to back
        apply_stimulus(8'h01, 16'h0000, 4'd1, 16'h0000);
        apply_stimulus(8'h01, 16'h0000, 4'd1, 16'h0001);
        apply_stimulus(8'h01, 16'h0000, 4'd1, 16'h0002);
        check_output("pc_after3", mem_addr, 16'h0003);
        check_output("req_cycles", 16'(req_cycles), 16'd3);

        apply_stimulus(8'h35, 16'h1234, 4'd5, 16'h0003);
        check_output("wb_r5", other_register, 16'h1234);
        check_output("wb_pc", mem_addr, 16'h0004);

        apply_stimulus(8'h00, 16'h0040, 4'd0, 16'h0004);
        check_output("wb_r0", working_register, 16'h0040);
        apply_stimulus(8'h20, working_register, 4'd14, 16'h0005);
        check_output("jump_pc", mem_addr, 16'h0040);

        apply_stimulus(8'h21, 16'hFFFF, 4'd14, 16'h0040);
        check_output("jump_ffff", mem_addr, 16'hFFFF);
        apply_stimulus(8'h22, 16'h0000, 4'd1, 16'hFFFF);
        check_output("wrap_pc", mem_addr, 16'h0000);

        apply_stimulus(8'h0C, 16'hA5A5, 4'd12, 16'h0000);
        check_output("sr_write", status_register, 16'hA5A5);
        check_output("sr_read", other_register, 16'hA5A5);

        // Slow memory: five cycles of no ack while data wiggles
        wait_req();
        for (int i = 0; i < 5; i++) begin
            mem_data_in = (i % 2 == 0) ? 8'hFF : 8'h5A;
            tick();
            check_output("hold_req", {15'd0, mem_req}, 16'h0001);
            check_output("hold_addr", mem_addr, 16'h0001);
            check_output("hold_instr", {8'h00, instruction}, 16'h000C);
        end
        mem_data_in = 8'h47;
        mem_ack     = 1'b1;
        addr_q.push_back(16'h0001);
        tick();
        mem_ack     = 1'b0;
        mem_data_in = 8'h00;
        check_output("late_instr", {8'h00, instruction}, 16'h0047);
        tick();
        check_output("late_pc", mem_addr, 16'h0002);

        // Sleep, with wake held through the EXEC of the sleep opcode
        wake = 1'b1;
        apply_stimulus(8'h08, 16'h0000, 4'd1, 16'h0002);
        wake = 1'b0;
        check_output("sleep_rise", {15'd0, sleeping}, 16'h0001);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_output("sleep_req", {15'd0, mem_req}, 16'h0000);
            check_output("sleep_hold", {15'd0, sleeping}, 16'h0001);
        end
        wake = 1'b1;
        tick();
        wake = 1'b0;
        check_output("wake_sleep", {15'd0, sleeping}, 16'h0000);
        check_output("wake_req", {15'd0, mem_req}, 16'h0001);
        check_output("wake_pc", mem_addr, 16'h0003);

        apply_stimulus(8'h08, 16'h0000, 4'd1, 16'h0003);
        check_output("sleep2", {15'd0, sleeping}, 16'h0001);
        #2;
        reset = 1'b0;
        #1;
        check_output("rst_sleep2", {15'd0, sleeping}, 16'h0000);
        check_output("rst_pc2", mem_addr, 16'h0000);
        check_output("rst_sr2", status_register, 16'h0000);
        check_output("addr_q_empty", 16'(addr_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
